// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoded ops, default width.
// Pure declarations; no latency and no backpressure.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_e;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_PM   = 3'd1,
        OP_P2M  = 3'd2,
        OP_NM   = 3'd3,
        OP_N2M  = 3'd4
    } booth_op_e;

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/done request bus between the ALU issue logic (master) and the Booth multiplier (slave).
// Operands ride with start; start is only honoured while busy is low.
interface booth_multiplier_if
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: {Q[1],Q[0],Q[-1]} triplet to partial-product operation.
// Combinational, zero latency, no backpressure.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet_i,
    output booth_op_e  op_o
);
    always_comb begin
        op_o = OP_ZERO;
        case (triplet_i)
            3'b001, 3'b010: op_o = OP_PM;
            3'b011:         op_o = OP_P2M;
            3'b100:         op_o = OP_N2M;
            3'b101, 3'b110: op_o = OP_NM;
            default:        op_o = OP_ZERO;
        endcase
    end
endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH split into HI/LO.
// done pulses WIDTH/2+1 clocks after the accepted start; start is ignored while busy.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    booth_multiplier_if.slave bus
);
    localparam int STEPS = WIDTH / 2;
    localparam int AW    = WIDTH + 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       m_q;
    logic [AW-1:0]       a_q;
    logic [WIDTH-1:0]    q_q;
    logic                qm1_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    hi_q, lo_q;
    logic                done_q;

    booth_op_e           op;
    logic [AW-1:0]       m2;
    logic [AW-1:0]       addend;
    logic [AW-1:0]       a_sum;
    logic signed [AW+WIDTH:0] shifted;

    booth_recoder u_recoder (
        .triplet_i ({q_q[1:0], qm1_q}),
        .op_o      (op)
    );

    // 2M still fits in AW bits even for the most-negative operand.
    assign m2 = {m_q[AW-2:0], 1'b0};

    always_comb begin
        addend = '0;
        case (op)
            OP_PM:   addend = m_q;
            OP_P2M:  addend = m2;
            OP_NM:   addend = -m_q;
            OP_N2M:  addend = -m2;
            default: addend = '0;
        endcase
        a_sum   = a_q + addend;
        shifted = $signed({a_sum, q_q, qm1_q}) >>> 2;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CW'(STEPS - 1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_q   <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                        q_q   <= bus.multiplier;
                        qm1_q <= 1'b0;
                        a_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    a_q   <= shifted[AW+WIDTH:WIDTH+1];
                    q_q   <= shifted[WIDTH:1];
                    qm1_q <= shifted[0];
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_DONE: begin
                    hi_q   <= a_q[WIDTH-1:0];
                    lo_q   <= q_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.product_hi = hi_q;
    assign bus.product_lo = lo_q;

endmodule
